// File: rtl/ic_l2_cache.sv
// Two-way set-associative L2 instruction cache: 3-cycle pipelined lookup, 4-beat fill capture.
// Define IC_L2_STATS_EN to build the saturating hit/miss lookup counters.
module ic_l2_cache #(
    parameter int unsigned ABW       = 64,
    parameter int unsigned IDXW      = 8,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [ABW-1:0] rd_adr_i,
    output logic           ihit_o,
    output logic [514:0]   rd_dat_o,
    input  logic           nxt_i,
    input  logic           ld_i,
    input  logic [2:0]     cnt_i,
    input  logic [ABW-1:0] ld_adr_i,
    input  logic           ack_i,
    input  logic           err_i,
    input  logic           tlbmiss_i,
    input  logic           exv_i,
    input  logic [127:0]   dat_i,
    input  logic           invline_i,
    input  logic [ABW-1:0] invadr_i,
    input  logic           invall_i,
    output logic [31:0]    hit_ctr_o,
    output logic [31:0]    miss_ctr_o
);
    localparam int unsigned TagW     = ABW - 5 - IDXW;
    localparam int unsigned Sets     = 2 ** IDXW;
    localparam logic [639:0] FaultPat = {16{40'hD2}};

    typedef enum logic [1:0] {FillIdle, FillBeat, FillCommit} fill_state_e;

    logic [TagW-1:0]       tag_mem [2][Sets];
    logic [514:0]          dat_mem [2][Sets];
    logic [1:0][Sets-1:0]  valid_q;

    logic [ABW-6:0]  rd_line_q;
    logic [TagW-1:0] rd_tag_q;
    logic [1:0]      rd_vld_q;
    logic [TagW-1:0] rd_way_tag_q [2];
    logic [514:0]    rd_way_dat_q [2];
    logic [1:0]      way_hit;
    logic [IDXW-1:0] rd_idx;

    fill_state_e     fill_state_q;
    logic            ld_q;
    logic [ABW-6:0]  fill_line_q;
    logic [3:0][127:0] beat_q;
    logic [2:0]      fill_code_q;
    logic [7:0]      lfsr_q;

    logic [IDXW-1:0] fill_idx, inv_idx;
    logic [TagW-1:0] fill_tag, inv_tag;
    logic            inv_same, commit_en, victim, beat;
    logic [1:0]      inv_hit;
    logic            unused_low;

    assign rd_idx     = rd_line_q[IDXW-1:0];
    assign fill_idx   = fill_line_q[IDXW-1:0];
    assign fill_tag   = fill_line_q[ABW-6:IDXW];
    assign inv_idx    = invadr_i[IDXW+4:5];
    assign inv_tag    = invadr_i[ABW-1:IDXW+5];
    assign beat       = ack_i | err_i | tlbmiss_i | exv_i;
    assign unused_low = ^{rd_adr_i[4:0], ld_adr_i[4:0], invadr_i[4:0]};

    // A same-line invalidate in the commit cycle wins, so the line is never left stale-valid.
    assign inv_same  = invline_i && (invadr_i[ABW-1:5] == fill_line_q);
    assign commit_en = (fill_state_q == FillCommit) && (fill_code_q == 3'd0) &&
                       !invall_i && !inv_same;

    always_comb begin
        way_hit = '0;
        inv_hit = '0;
        victim  = lfsr_q[0];
        if (!valid_q[0][fill_idx]) begin
            victim = 1'b0;
        end else if (!valid_q[1][fill_idx]) begin
            victim = 1'b1;
        end
        for (int w = 0; w < 2; w++) begin
            way_hit[w] = rd_vld_q[w] && (rd_way_tag_q[w] == rd_tag_q);
            inv_hit[w] = invline_i && valid_q[w][inv_idx] && (tag_mem[w][inv_idx] == inv_tag);
        end
    end

    // Array read/write ports; read-first, so a same-set commit is seen one lookup later.
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < 2; w++) begin
            rd_way_tag_q[w] <= tag_mem[w][rd_idx];
            rd_way_dat_q[w] <= dat_mem[w][rd_idx];
        end
        if (commit_en) begin
            tag_mem[victim][fill_idx] <= fill_tag;
            dat_mem[victim][fill_idx] <= {fill_code_q, beat_q};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_line_q <= '0;
            rd_tag_q  <= '0;
            rd_vld_q  <= '0;
            ihit_o    <= 1'b0;
            rd_dat_o  <= '0;
        end else begin
            rd_line_q <= rd_adr_i[ABW-1:5];
            rd_tag_q  <= rd_line_q[ABW-6:IDXW];
            rd_vld_q  <= {valid_q[1][rd_idx], valid_q[0][rd_idx]};
            ihit_o    <= |way_hit;
            rd_dat_o  <= way_hit[0] ? rd_way_dat_q[0] : (way_hit[1] ? rd_way_dat_q[1] : '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
        end else if (invall_i) begin
            valid_q <= '0;
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (inv_hit[w]) valid_q[w][inv_idx] <= 1'b0;
            end
            if (commit_en) valid_q[victim][fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (nxt_i) begin
            lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fill_state_q <= FillIdle;
            ld_q         <= 1'b0;
            fill_line_q  <= '0;
            beat_q       <= '0;
            fill_code_q  <= 3'd0;
        end else begin
            ld_q <= ld_i;
            case (fill_state_q)
                FillIdle: begin
                    if (ld_i && !ld_q) begin
                        fill_line_q  <= ld_adr_i[ABW-1:5];
                        beat_q       <= '0;
                        fill_code_q  <= 3'd0;
                        fill_state_q <= FillBeat;
                    end
                end
                FillBeat: begin
                    if (!ld_i) begin
                        fill_state_q <= FillIdle;
                    end else if (beat) begin
                        if (tlbmiss_i || exv_i || err_i) begin
                            fill_code_q  <= tlbmiss_i ? 3'd1 : (exv_i ? 3'd2 : 3'd3);
                            beat_q       <= FaultPat[511:0];
                            fill_state_q <= FillCommit;
                        end else begin
                            beat_q[cnt_i[1:0]] <= dat_i;
                            if (cnt_i == 3'd3) fill_state_q <= FillCommit;
                        end
                    end
                end
                FillCommit: fill_state_q <= FillIdle;
                default:    fill_state_q <= FillIdle;
            endcase
        end
    end

`ifdef IC_L2_STATS_EN
    logic [31:0] hit_ctr_q, miss_ctr_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_ctr_q  <= 32'd0;
            miss_ctr_q <= 32'd0;
        end else if (|way_hit) begin
            if (hit_ctr_q != 32'hFFFF_FFFF) hit_ctr_q <= hit_ctr_q + 32'd1;
        end else begin
            if (miss_ctr_q != 32'hFFFF_FFFF) miss_ctr_q <= miss_ctr_q + 32'd1;
        end
    end

    assign hit_ctr_o  = hit_ctr_q;
    assign miss_ctr_o = miss_ctr_q;
`else
    assign hit_ctr_o  = 32'd0;
    assign miss_ctr_o = 32'd0;
`endif
endmodule
